// File: rtl/timer_pkg.sv
// Shared definitions for the down timer: FSM state encoding and default width.
package timer_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/eight_bit_down_timer_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface eight_bit_down_timer_if #(parameter int WIDTH = timer_pkg::DEFAULT_WIDTH);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (output load, load_value, enable,
                  input  count_out, busy, done, zero);
  modport slave  (input  load, load_value, enable,
                  output count_out, busy, done, zero);
endinterface

// File: rtl/down_counter_core.sv
// Loadable down counter built as a borrow chain; never decremented past zero by its user.
module down_counter_core
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  logic [WIDTH-1:0] borrow;

  // Bit i toggles when decrementing and every lower bit is already 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
    if (i == 0) begin : g_lsb
      assign borrow[i] = dec;
    end else begin : g_upper
      assign borrow[i] = dec & ~(|count[i-1:0]);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)     count <= '0;
    else if (load) count <= load_value;
    else           count <= count ^ borrow;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/eight_bit_down_timer.sv
// Down timer: IDLE/RUN/DONE control around a borrow-chain counter, optional periodic reload.
module eight_bit_down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                   clock,
  input  logic                   clear,
  eight_bit_down_timer_if.slave  bus
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] count;
  logic             core_load;
  logic [WIDTH-1:0] core_value;
  logic             dec;
  logic             last;

  assign last = (count == WIDTH'(1));

  // An external load beats the DONE-cycle reload; decrement only in RUN and never below 0.
  assign core_load  = bus.load | (AUTO_RELOAD && state == S_DONE);
  assign core_value = bus.load ? bus.load_value : reload_reg;
  assign dec        = (state == S_RUN) & bus.enable & ~bus.load & (count != '0);

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clock      (clock),
    .clear      (clear),
    .load       (core_load),
    .load_value (core_value),
    .dec        (dec),
    .count      (count),
    .zero       (bus.zero)
  );

  assign bus.count_out = count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)         reload_reg <= '0;
    else if (bus.load) reload_reg <= bus.load_value;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (bus.load) begin
      state_nxt = (bus.load_value != '0) ? S_RUN : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_RUN:   state_nxt = (bus.enable && last) ? S_DONE : S_RUN;
        S_DONE:  state_nxt = AUTO_RELOAD ? S_RUN : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end
endmodule

// File: tb/tb_eight_bit_down_timer.sv
// Directed bench for eight_bit_down_timer: one-shot instance and an auto-reload instance.
module tb_eight_bit_down_timer;
  logic clock = 1'b0;
  logic clear;
  int   n_chk  = 0;
  int   n_fail = 0;

  eight_bit_down_timer_if #(.WIDTH(8)) bus0 ();
  eight_bit_down_timer_if #(.WIDTH(8)) bus1 ();

  eight_bit_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
    .clock (clock), .clear (clear), .bus (bus0.slave));
  eight_bit_down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
    .clock (clock), .clear (clear), .bus (bus1.slave));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ld0(input logic [7:0] v, input logic en);
    bus0.load = 1'b1; bus0.load_value = v; bus0.enable = en;
    tick();
    bus0.load = 1'b0;
  endtask

  logic [7:0] ar_cnt  [8] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
  logic [7:0] pause_c [5] = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
  logic       pause_e [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       early;

  initial begin
    clear = 1'b1;
    bus0.load = 1'b0; bus0.load_value = '0; bus0.enable = 1'b0;
    bus1.load = 1'b0; bus1.load_value = '0; bus1.enable = 1'b0;
    #12;
    chk("rst_count", bus0.count_out, 0);
    chk("rst_busy",  bus0.busy, 0);
    chk("rst_done",  bus0.done, 0);
    chk("rst_zero",  bus0.zero, 1);
    clear = 1'b0;
    tick();

    // Asynchronous clear mid-run, observed before any clock edge
    ld0(8'h37, 1'b0);
    chk("pre_clr_count", bus0.count_out, 8'h37);
    chk("pre_clr_busy",  bus0.busy, 1);
    #2 clear = 1'b1;
    #1;
    chk("aclr_count", bus0.count_out, 0);
    chk("aclr_busy",  bus0.busy, 0);
    chk("aclr_done",  bus0.done, 0);
    chk("aclr_zero",  bus0.zero, 1);
    tick();
    clear = 1'b0;
    tick();
    chk("post_clr_busy", bus0.busy, 0);

    // Basic countdown from 5
    ld0(8'h05, 1'b1);
    chk("basic_load", bus0.count_out, 5);
    chk("basic_busy", bus0.busy, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("basic_count", bus0.count_out, 32'(5 - k));
      chk("basic_done",  bus0.done, (k == 5));
      chk("basic_busy_run", bus0.busy, (k != 5));
    end
    tick();
    chk("basic_idle_done", bus0.done, 0);
    chk("basic_idle_busy", bus0.busy, 0);
    chk("basic_idle_cnt",  bus0.count_out, 0);

    // Pause with enable pattern 1,0,0,1,1
    ld0(8'h03, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus0.enable = pause_e[k];
      tick();
      chk("pause_count", bus0.count_out, pause_c[k]);
      chk("pause_done",  bus0.done, (k == 4));
    end
    bus0.enable = 1'b1;

    // Load override in RUN: no decrement on the load edge
    ld0(8'h10, 1'b1);
    repeat (4) tick();
    chk("ovr_pre", bus0.count_out, 8'h0C);
    ld0(8'h02, 1'b1);
    chk("ovr_load", bus0.count_out, 2);
    tick();
    chk("ovr_c1", bus0.count_out, 1);
    chk("ovr_d1", bus0.done, 0);
    tick();
    chk("ovr_c0", bus0.count_out, 0);
    chk("ovr_d0", bus0.done, 1);

    // Load during DONE: done still visible, load wins next edge
    ld0(8'h04, 1'b1);
    chk("ldd_cnt", bus0.count_out, 4);
    chk("ldd_busy", bus0.busy, 1);
    repeat (3) tick();
    tick();
    chk("ldd_done_before", bus0.done, 1);
    ld0(8'h02, 1'b1);
    chk("ldd_reload_cnt", bus0.count_out, 2);
    chk("ldd_reload_busy", bus0.busy, 1);
    repeat (3) tick();

    // Load of zero: IDLE, no done
    ld0(8'h00, 1'b1);
    chk("z_busy", bus0.busy, 0);
    chk("z_zero", bus0.zero, 1);
    chk("z_done", bus0.done, 0);
    tick();
    chk("z_done2", bus0.done, 0);

    // Load of FF: done after exactly 255 enabled edges
    ld0(8'hFF, 1'b1);
    chk("ff_load", bus0.count_out, 8'hFF);
    early = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255 && bus0.done) early = 1'b1;
      if (k == 254) chk("ff_254", bus0.count_out, 1);
    end
    chk("ff_early_done", early, 0);
    chk("ff_done", bus0.done, 1);
    chk("ff_count", bus0.count_out, 0);
    bus0.enable = 1'b0;

    // Auto-reload: period N+1 with done pulses
    bus1.load = 1'b1; bus1.load_value = 8'h03; bus1.enable = 1'b1;
    tick();
    bus1.load = 1'b0;
    chk("ar_load", bus1.count_out, 3);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ar_count", bus1.count_out, ar_cnt[k]);
      chk("ar_done",  bus1.done, (k == 2 || k == 6));
      chk("ar_busy",  bus1.busy, !(k == 2 || k == 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
